// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and the
// default target addresses used across the I2C blocks.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } i2c_state_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [6:0] I2C_TGT_ADDR_0 = 7'h10;
   localparam logic [6:0] I2C_TGT_ADDR_1 = 7'h20;
   localparam logic [6:0] I2C_TGT_ADDR_2 = 7'h30;
   localparam logic [6:0] I2C_TGT_ADDR_3 = 7'h40;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Local side port of the I2C register target: combinational register read,
// bus-write strobe and busy indication.
interface i2c_reg_target_if #(
   parameter int AW = 4
);
   logic [AW-1:0] reg_rd_addr;
   logic [7:0]    reg_rd_data;
   logic          wr_strobe;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;

   modport master (
      output reg_rd_addr,
      input  reg_rd_data, wr_strobe, wr_addr, wr_data, busy
   );

   modport slave (
      input  reg_rd_addr,
      output reg_rd_data, wr_strobe, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/i2c_bus_cond.sv
// SCL/SDA conditioning: 2-flop synchronizers, then single-clk edge, START and
// STOP pulses, 3 clk behind the pins. Reset holds the idle (high) bus level.
module i2c_bus_cond (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_s_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);
   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_prev_q, sda_prev_q;
   logic       scl_s, sda_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];

   assign sda_s_o     = sda_s;
   assign scl_rise_o  = scl_s & ~scl_prev_q;
   assign scl_fall_o  = ~scl_s & scl_prev_q;
   // SCL must be high on both samples so a data change around an SCL edge is not taken as START/STOP
   assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// Bus writes strobe the side port one clk after the 8th SCL rise; SCL is never stretched.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = I2C_TGT_ADDR_3,
   parameter int         NREGS      = 16,
   parameter int         AW         = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            scl,
   inout  wire             sda,
   i2c_reg_target_if.slave rif
);
   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_cond u_cond (
      .clk         (clk),
      .reset       (reset),
      .scl_i       (scl),
      .sda_i       (sda),
      .sda_s_o     (sda_s),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_det_o (start_det),
      .stop_det_o  (stop_det)
   );

   i2c_state_e    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          wr_strobe_q, strobe_d;
   logic [AW-1:0] wr_addr_q, waddr_d;
   logic [7:0]    wr_data_q, wdata_d;
   logic [7:0]    regs_q [NREGS];
   logic          reg_we, load_rd;
   logic [7:0]    byte_in, rd_byte;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      ptr_d    = ptr_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      strobe_d = 1'b0;
      waddr_d  = wr_addr_q;
      wdata_d  = wr_data_q;
      reg_we   = 1'b0;
      load_rd  = 1'b0;
      byte_in  = {sr_q[6:0], sda_s};
      rd_byte  = regs_q[ptr_q];

      if (stop_det) begin
         state_d = IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d = ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  sr_d  = byte_in;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = '0;
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                           state_d = ADDR_ACK;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = IGNORE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = byte_in[AW-1:0];
                        state_d = PTR_ACK;
                     end else begin
                        reg_we   = 1'b1;
                        strobe_d = 1'b1;
                        waddr_d  = ptr_q;
                        wdata_d  = byte_in;
                        ptr_d    = ptr_q + 1'b1;
                        state_d  = WDATA_ACK;
                     end
                  end
               end
            end
            // oe_q doubles as the phase: first fall starts the ACK, second fall ends it
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d = 1'b0;
                     if (state_q == ADDR_ACK && sr_q[0]) load_rd = 1'b1;
                     else if (state_q == ADDR_ACK)        state_d = PTR;
                     else                                 state_d = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = RDATA_ACK;
                  end else begin
                     sr_d = {sr_q[6:0], 1'b0};
                     oe_d = ~sr_q[6];
                  end
               end
            end
            // cnt_q==1 marks an ACK seen on the rise, so the next fall loads the next byte
            RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_s == I2C_NACK) state_d = IGNORE;
                  else                   cnt_d   = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  load_rd = 1'b1;
               end
            end
            IDLE, IGNORE: ;
            default: state_d = IDLE;
         endcase

         if (load_rd) begin
            sr_d    = rd_byte;
            ptr_d   = ptr_q + 1'b1;
            oe_d    = ~rd_byte[7];
            cnt_d   = '0;
            state_d = RDATA;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         ptr_q       <= '0;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         ptr_q       <= ptr_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= strobe_d;
         wr_addr_q   <= waddr_d;
         wr_data_q   <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (reg_we) begin
         regs_q[ptr_q] <= byte_in;
      end
   end

   assign sda             = oe_q ? 1'b0 : 1'bz;
   assign rif.reg_rd_data = regs_q[rif.reg_rd_addr];
   assign rif.wr_strobe   = wr_strobe_q;
   assign rif.wr_addr     = wr_addr_q;
   assign rif.wr_data     = wr_data_q;
   assign rif.busy        = busy_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged bus master plus side-port checks.
module tb_i2c_reg_target;
   localparam int Q = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda_low = 1'b0;
   wire  sda;

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_reg_target_if #(.AW(4)) rif();

   i2c_reg_target #(.SLAVE_ADDR(7'h40), .NREGS(16), .AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .scl   (m_scl),
      .sda   (sda),
      .rif   (rif)
   );

   int errors = 0;
   int checks = 0;
   logic [11:0] strobe_log[$];
   int busy_cnt = 0;
   int low_cnt  = 0;

   always @(negedge clk) begin
      if (rif.wr_strobe === 1'b1) strobe_log.push_back({rif.wr_addr, rif.wr_data});
      if (rif.busy === 1'b1) busy_cnt++;
      if (sda === 1'b0 && !m_sda_low) low_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start;
      m_sda_low = 1'b1; wclk(Q);
      m_scl = 1'b0;     wclk(Q);
   endtask

   task automatic bus_rstart;
      m_sda_low = 1'b0; wclk(Q);
      m_scl = 1'b1;     wclk(Q);
      m_sda_low = 1'b1; wclk(Q);
      m_scl = 1'b0;     wclk(Q);
   endtask

   task automatic bus_stop;
      m_sda_low = 1'b1; wclk(Q);
      m_scl = 1'b1;     wclk(Q);
      m_sda_low = 1'b0; wclk(Q);
   endtask

   task automatic put_bit(input logic b);
      m_sda_low = ~b; wclk(Q);
      m_scl = 1'b1;   wclk(2 * Q);
      m_scl = 1'b0;   wclk(Q);
   endtask

   task automatic get_bit(output logic b);
      m_sda_low = 1'b0; wclk(Q);
      m_scl = 1'b1;     wclk(Q);
      b = sda;          wclk(Q);
      m_scl = 1'b0;     wclk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(ack);
   endtask

   task automatic test_reset;
      reset = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; rif.reg_rd_addr = 4'd0;
      wclk(5);
      checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rif.busy); end
      checks++; if (rif.wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", rif.wr_strobe); end
      checks++; if (rif.wr_addr !== 4'h0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", rif.wr_addr); end
      checks++; if (rif.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", rif.wr_data); end
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda); end
      reset = 1'b0;
      wclk(5);
      checks++; if (rif.reg_rd_data !== 8'h00) begin errors++; $display("FAIL reset_reg0 got=%h exp=00", rif.reg_rd_data); end
      rif.reg_rd_addr = 4'd9; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'h00) begin errors++; $display("FAIL reset_reg9 got=%h exp=00", rif.reg_rd_data); end
   endtask

   task automatic test_write;
      int base = strobe_log.size();
      logic a0, a1, a2, a3;
      bus_start;
      send_byte(8'h80, a0);
      checks++; if (rif.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_high got=%b exp=1", rif.busy); end
      send_byte(8'h03, a1);
      send_byte(8'hA5, a2);
      send_byte(8'h5A, a3);
      bus_stop; wclk(4);
      checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks got=%b exp=0000", {a0, a1, a2, a3}); end
      checks++;
      if (strobe_log.size() != base + 2) begin
         errors++; $display("FAIL wr_strobe_count got=%0d exp=2", strobe_log.size() - base);
      end else begin
         checks++; if (strobe_log[base] !== 12'h3A5) begin errors++; $display("FAIL wr_strobe0 got=%h exp=3a5", strobe_log[base]); end
         checks++; if (strobe_log[base+1] !== 12'h45A) begin errors++; $display("FAIL wr_strobe1 got=%h exp=45a", strobe_log[base+1]); end
      end
      rif.reg_rd_addr = 4'd4; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'h5A) begin errors++; $display("FAIL wr_reg4 got=%h exp=5a", rif.reg_rd_data); end
      rif.reg_rd_addr = 4'd3; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'hA5) begin errors++; $display("FAIL wr_reg3 got=%h exp=a5", rif.reg_rd_data); end
      checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", rif.busy); end
   endtask

   task automatic test_read;
      int base = strobe_log.size();
      logic a0, a1, a2;
      logic [7:0] d0, d1, d2;
      bus_start;
      send_byte(8'h80, a0);
      send_byte(8'h02, a1);
      bus_rstart;
      send_byte(8'h81, a2);
      recv_byte(1'b0, d0);
      recv_byte(1'b0, d1);
      recv_byte(1'b1, d2);
      bus_stop; wclk(4);
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2}); end
      checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rd_byte0 got=%h exp=00", d0); end
      checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL rd_byte1 got=%h exp=a5", d1); end
      checks++; if (d2 !== 8'h5A) begin errors++; $display("FAIL rd_byte2 got=%h exp=5a", d2); end
      checks++; if (strobe_log.size() != base) begin errors++; $display("FAIL rd_no_strobe got=%0d exp=0", strobe_log.size() - base); end
      checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got=%b exp=0", rif.busy); end
   endtask

   task automatic test_wrap;
      int base = strobe_log.size();
      logic a;
      logic [7:0] d;
      bus_start; send_byte(8'h80, a); send_byte(8'h01, a); send_byte(8'h77, a); bus_stop;
      bus_start; send_byte(8'h80, a); send_byte(8'h0F, a); send_byte(8'h11, a); send_byte(8'h22, a); bus_stop;
      wclk(4);
      checks++;
      if (strobe_log.size() != base + 3) begin
         errors++; $display("FAIL wrap_strobe_count got=%0d exp=3", strobe_log.size() - base);
      end else begin
         checks++; if (strobe_log[base+1] !== 12'hF11) begin errors++; $display("FAIL wrap_strobe15 got=%h exp=f11", strobe_log[base+1]); end
         checks++; if (strobe_log[base+2] !== 12'h022) begin errors++; $display("FAIL wrap_strobe0 got=%h exp=022", strobe_log[base+2]); end
      end
      rif.reg_rd_addr = 4'd15; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'h11) begin errors++; $display("FAIL wrap_reg15 got=%h exp=11", rif.reg_rd_data); end
      rif.reg_rd_addr = 4'd0; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'h22) begin errors++; $display("FAIL wrap_reg0 got=%h exp=22", rif.reg_rd_data); end
      bus_start; send_byte(8'h81, a); recv_byte(1'b1, d); bus_stop;
      checks++; if (d !== 8'h77) begin errors++; $display("FAIL wrap_read_ptr1 got=%h exp=77", d); end
   endtask

   task automatic test_nomatch;
      int base = strobe_log.size();
      int low0 = low_cnt;
      int busy0 = busy_cnt;
      logic a, a2;
      logic [7:0] addr;
      for (int k = 0; k < 2; k++) begin
         addr = (k == 0) ? 8'h82 : 8'h00;
         bus_start;
         send_byte(addr, a);
         send_byte(8'h3C, a2);
         bus_stop;
         checks++; if (a !== 1'b1) begin errors++; $display("FAIL nomatch_nack addr=%h got=%b exp=1", addr, a); end
      end
      wclk(4);
      checks++; if (low_cnt != low0) begin errors++; $display("FAIL nomatch_sda_low got=%0d exp=0", low_cnt - low0); end
      checks++; if (busy_cnt != busy0) begin errors++; $display("FAIL nomatch_busy got=%0d exp=0", busy_cnt - busy0); end
      checks++; if (strobe_log.size() != base) begin errors++; $display("FAIL nomatch_strobe got=%0d exp=0", strobe_log.size() - base); end
   endtask

   task automatic test_abort;
      int base = strobe_log.size();
      logic a;
      logic [7:0] d;
      bus_start; send_byte(8'h80, a); send_byte(8'h07, a); send_byte(8'hE7, a); bus_stop;
      bus_start; send_byte(8'h80, a); send_byte(8'h07, a);
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
      bus_stop; wclk(4);
      checks++; if (strobe_log.size() != base + 1) begin errors++; $display("FAIL abort_strobe_count got=%0d exp=1", strobe_log.size() - base); end
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL abort_sda got=%b exp=1", sda); end
      checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", rif.busy); end
      rif.reg_rd_addr = 4'd7; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'hE7) begin errors++; $display("FAIL abort_reg7 got=%h exp=e7", rif.reg_rd_data); end
      bus_start; send_byte(8'h81, a); recv_byte(1'b1, d); bus_stop;
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL abort_idle_ack got=%b exp=0", a); end
      checks++; if (d !== 8'hE7) begin errors++; $display("FAIL abort_ptr_kept got=%h exp=e7", d); end
   endtask

   task automatic test_reset_mid;
      logic a;
      bus_start;
      for (int i = 7; i >= 0; i--) put_bit(i == 7);
      m_sda_low = 1'b0;
      wclk(3);
      checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rmid_ack_low got=%b exp=0", sda); end
      reset = 1'b1;
      wclk(1);
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rmid_sda_release got=%b exp=1", sda); end
      checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", rif.busy); end
      for (int i = 0; i < 16; i++) begin
         rif.reg_rd_addr = 4'(i); wclk(1);
         checks++; if (rif.reg_rd_data !== 8'h00) begin errors++; $display("FAIL rmid_reg%0d got=%h exp=00", i, rif.reg_rd_data); end
      end
      reset = 1'b0;
      m_scl = 1'b1;
      wclk(Q);
      bus_start; send_byte(8'h80, a); send_byte(8'h05, a); send_byte(8'h3C, a); bus_stop;
      rif.reg_rd_addr = 4'd5; wclk(1);
      checks++; if (rif.reg_rd_data !== 8'h3C) begin errors++; $display("FAIL rmid_after_reg5 got=%h exp=3c", rif.reg_rd_data); end
   endtask

   initial begin
      rif.reg_rd_addr = 4'd0;
      test_reset;
      test_write;
      test_read;
      test_wrap;
      test_nomatch;
      test_abort;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
